// File: rtl/md_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit:
// MD opcodes, FSM state encoding and the latency counter width.
package md_pkg;

  localparam int CNT_W = 4;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational mult/div datapath returning {hi,lo}.
// Ports: op, rs, rt, current hi/lo in; 2*WIDTH result out.
module md_calc
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   rs,
  input  logic [WIDTH-1:0]   rt,
  input  logic [WIDTH-1:0]   hi,
  input  logic [WIDTH-1:0]   lo,
  output logic [2*WIDTH-1:0] result
);

  logic [2*WIDTH-1:0] sx, sy, smul, umul;
  logic [WIDTH-1:0]   abs_a, abs_b, aq, ar;
  logic [WIDTH-1:0]   sq, sr, uq, ur;
  logic               neg_a, neg_b;

  assign sx   = {{WIDTH{rs[WIDTH-1]}}, rs};
  assign sy   = {{WIDTH{rt[WIDTH-1]}}, rt};
  assign smul = sx * sy;
  assign umul = {{WIDTH{1'b0}}, rs} * {{WIDTH{1'b0}}, rt};

  // Signed divide through magnitudes so MIN/-1 wraps
  // instead of relying on signed-division corner cases.
  assign neg_a = rs[WIDTH-1];
  assign neg_b = rt[WIDTH-1];
  assign abs_a = neg_a ? -rs : rs;
  assign abs_b = neg_b ? -rt : rt;
  assign aq    = abs_a / abs_b;
  assign ar    = abs_a % abs_b;
  assign sq    = (neg_a ^ neg_b) ? -aq : aq;
  assign sr    = neg_a ? -ar : ar;
  assign uq    = rs / rt;
  assign ur    = rs % rt;

  always_comb begin
    result = '0;
    case (op)
      MD_MULT:  result = smul;
      MD_MULTU: result = umul;
      MD_DIV:   result = (rt == '0) ? {hi, lo} : {sr, sq};
      MD_DIVU:  result = (rt == '0) ? {hi, lo} : {ur, uq};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multi-cycle mult/div unit owning HI/LO.
// Ports: clk, reset_n, md_op/md_rs/md_rt in; start, busy, hi, lo, rd out.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int WIDTH       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] md_rs,
  input  logic [WIDTH-1:0] md_rt,
  output logic             md_start,
  output logic             md_busy,
  output logic [WIDTH-1:0] md_hi,
  output logic [WIDTH-1:0] md_lo,
  output logic [WIDTH-1:0] md_rd
);

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  md_state_t          state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi, lo, pend_hi, pend_lo;
  logic [2*WIDTH-1:0] calc;
  logic               done;

  md_calc #(.WIDTH(WIDTH)) u_calc (
    .op     (md_op),
    .rs     (md_rs),
    .rt     (md_rt),
    .hi     (hi),
    .lo     (lo),
    .result (calc)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  assign done = (state == BUSY) && (cnt <= ONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (md_start) state_nxt = BUSY;
      BUSY:    if (done)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    md_start = (state == IDLE) && (is_mul(md_op) || is_div(md_op));
    md_busy  = (state == BUSY);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (md_start) begin
      {pend_hi, pend_lo} <= calc;
      cnt <= is_div(md_op) ? DIV_N : MULT_N;
    end else if (state == BUSY) begin
      cnt <= cnt - ONE;
      if (done) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (md_op == MD_MTHI) begin
      hi <= md_rs;
    end else if (md_op == MD_MTLO) begin
      lo <= md_rs;
    end
  end

  assign md_hi = hi;
  assign md_lo = lo;

  always_comb begin
    md_rd = '0;
    case (md_op)
      MD_MFHI: md_rd = hi;
      MD_MFLO: md_rd = lo;
      default: md_rd = '0;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: random and directed
// MD ops against an arithmetic reference model.
module tb_mult_div_unit;
  import md_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  md_op = MD_NONE;
  logic [31:0] md_rs = '0;
  logic [31:0] md_rt = '0;
  logic        md_start, md_busy;
  logic [31:0] md_hi, md_lo, md_rd;

  always #5 clk = ~clk;

  mult_div_unit #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC),
    .WIDTH      (32)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .md_op    (md_op),
    .md_rs    (md_rs),
    .md_rt    (md_rt),
    .md_start (md_start),
    .md_busy  (md_busy),
    .md_hi    (md_hi),
    .md_lo    (md_lo),
    .md_rd    (md_rd)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  bit          aborted = 0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_md(
    logic [3:0] op, logic [31:0] a, logic [31:0] b,
    logic [31:0] h, logic [31:0] l);
    longint          sa, sb2, q, r;
    longint unsigned ua, ub, uq, ur;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    case (op)
      MD_MULT:  return 64'(sa * sb2);
      MD_MULTU: return 64'(ua * ub);
      MD_DIV: begin
        if (b == 0) return {h, l};
        q = sa / sb2;
        r = sa % sb2;
        return {r[31:0], q[31:0]};
      end
      MD_DIVU: begin
        if (b == 0) return {h, l};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return {h, l};
    endcase
  endfunction

  // Monitor: a falling md_busy is a completed operation.
  initial begin
    int   cnt;
    bit   prev;
    exp_t e;
    cnt  = 0;
    prev = 0;
    forever begin
      @(negedge clk);
      if (md_busy) begin
        cnt++;
      end else if (prev) begin
        if (aborted) begin
          aborted = 0;
        end else if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got hi=%h lo=%h want none",
                   md_hi, md_lo);
        end else begin
          e = sb.pop_front();
          check("done_hi", md_hi, e.hi);
          check("done_lo", md_lo, e.lo);
          check("busy_len", 32'(cnt), 32'(e.cyc));
        end
        cnt = 0;
      end
      prev = md_busy;
    end
  end

  always @(posedge clk) begin
    if (reset_n && md_busy)
      assert (md_op != MD_MTHI && md_op != MD_MTLO)
        else $error("FAIL mt_while_busy: op %0d", md_op);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_calc(logic [3:0] op, logic [31:0] a,
                            logic [31:0] b);
    logic [63:0] r;
    exp_t        e;
    md_op = op;
    md_rs = a;
    md_rt = b;
    @(negedge clk);
    check("start", 32'(md_start), 32'd1);
    r     = ref_md(op, a, b, m_hi, m_lo);
    e.hi  = r[63:32];
    e.lo  = r[31:0];
    e.cyc = (op == MD_DIV || op == MD_DIVU) ? DC : MC;
    sb.push_back(e);
    m_hi  = e.hi;
    m_lo  = e.lo;
    step();
    md_op = MD_NONE;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!md_busy) return;
      step();
    end
    checks++;
    errors++;
    $display("FAIL busy_timeout: got busy=1 want 0");
  endtask

  task automatic mt(logic [3:0] op, logic [31:0] v);
    md_op = op;
    md_rs = v;
    step();
    md_op = MD_NONE;
    if (op == MD_MTHI) m_hi = v;
    else               m_lo = v;
  endtask

  task automatic mf(logic [3:0] op, logic [31:0] exp);
    md_op = op;
    @(negedge clk);
    check("md_rd", md_rd, exp);
    step();
    md_op = MD_NONE;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    md_op = MD_MFHI;
    @(negedge clk);
    check("rst_rd", md_rd, 32'h0);
    check("rst_busy", 32'(md_busy), 32'd0);
    check("rst_start", 32'(md_start), 32'd0);
    check("rst_hi", md_hi, 32'h0);
    check("rst_lo", md_lo, 32'h0);
    step();
    md_op = MD_NONE;

    issue_calc(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_idle();
    check("mult_hi", md_hi, 32'hFFFF_FFFF);
    check("mult_lo", md_lo, 32'hFFFF_FFFA);
    issue_calc(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_idle();
    check("multu_hi", md_hi, 32'h0000_0002);
    check("multu_lo", md_lo, 32'hFFFF_FFFA);
    issue_calc(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    check("div_hi", md_hi, 32'hFFFF_FFFF);
    check("div_lo", md_lo, 32'hFFFF_FFFD);
    issue_calc(MD_DIVU, 32'd7, 32'd2);
    wait_idle();
    check("divu_hi", md_hi, 32'd1);
    check("divu_lo", md_lo, 32'd3);

    mt(MD_MTHI, 32'h1234);
    mt(MD_MTLO, 32'h5678);
    issue_calc(MD_DIV, 32'd99, 32'd0);
    wait_idle();
    check("div0_hi", md_hi, 32'h1234);
    check("div0_lo", md_lo, 32'h5678);
    issue_calc(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    check("ovf_hi", md_hi, 32'h0);
    check("ovf_lo", md_lo, 32'h8000_0000);

    // Calc ops presented while busy must be ignored.
    issue_calc(MD_MULT, 32'd7, 32'd6);
    for (int i = 1; i <= MC; i++) begin
      md_op = MD_MULT;
      md_rs = $urandom;
      md_rt = $urandom;
      @(negedge clk);
      check("busy_nostart", 32'(md_start), 32'd0);
      step();
    end
    md_op = MD_NONE;
    wait_idle();
    check("nostart_lo", md_lo, 32'd42);

    mt(MD_MTLO, 32'hAAAA_5555);
    mf(MD_MFLO, 32'hAAAA_5555);
    mt(MD_MTHI, 32'h0BAD_F00D);
    mf(MD_MFHI, 32'h0BAD_F00D);

    md_op = 4'd12;
    md_rs = 32'hDEAD_BEEF;
    @(negedge clk);
    check("badop_start", 32'(md_start), 32'd0);
    check("badop_rd", md_rd, 32'h0);
    step();
    md_op = MD_NONE;
    check("badop_hi", md_hi, m_hi);
    check("badop_lo", md_lo, m_lo);

    for (int n = 0; n < 30; n++) begin
      op = 4'($urandom_range(1, 8));
      a  = pick();
      b  = ($urandom_range(0, 7) == 0) ? 32'h0 : pick();
      case (op)
        MD_MTHI, MD_MTLO: begin
          mt(op, a);
          check("rnd_hi", md_hi, m_hi);
          check("rnd_lo", md_lo, m_lo);
        end
        MD_MFHI: mf(op, m_hi);
        MD_MFLO: mf(op, m_lo);
        default: begin
          issue_calc(op, a, b);
          wait_idle();
        end
      endcase
    end

    // Reset in the middle of a multiply discards it.
    issue_calc(MD_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
    step();
    aborted = 1;
    reset_n = 1'b0;
    step();
    check("rstb_busy", 32'(md_busy), 32'd0);
    check("rstb_hi", md_hi, 32'h0);
    check("rstb_lo", md_lo, 32'h0);
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    reset_n = 1'b1;
    repeat (3) step();
    check("rstb_idle", 32'(md_busy), 32'd0);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_empty: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
